// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: streaming RGB point-operation processor with VSYNC/HSYNC frame timing
// Ports:
//   HCLK, HRESET         clock, synchronous active-low reset
//   start, mode, value   frame start request and per-frame operation select/amount
//   in_valid, in_ready   upstream beat handshake, in_data carries PPC packed RGB pixels
//   out_valid, out_data  processed beat, one cycle after its transfer
//   out_row, out_col     line index and first-pixel index of out_data
//   VSYNC, HSYNC, busy   framing status, ctrl_done pulses with the last output beat
module pixel_stream_proc #(
    parameter int WIDTH         = 768,
    parameter int HEIGHT        = 512,
    parameter int PPC           = 2,
    parameter int DATA_W        = 8,
    parameter int STARTUP_DELAY = 100,
    parameter int HSYNC_DELAY   = 160
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      start,
    input  logic [2:0]                mode,
    input  logic [DATA_W-1:0]         value,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PPC*3*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    output logic [PPC*3*DATA_W-1:0]   out_data,
    output logic [15:0]               out_row,
    output logic [15:0]               out_col,
    output logic                      VSYNC,
    output logic                      HSYNC,
    output logic                      busy,
    output logic                      ctrl_done
);
    localparam int PIX_W = 3 * DATA_W;
    localparam int CMAX  = (STARTUP_DELAY > HSYNC_DELAY) ? STARTUP_DELAY : HSYNC_DELAY;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA} state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt;
    logic [15:0]               row, col;
    logic [2:0]                mode_r;
    logic [DATA_W-1:0]         value_r;
    logic [PPC*3*DATA_W-1:0]   proc;
    logic                      xfer, line_end, frame_end;

    // Threshold compares the channel sum against 3*value; both fit in DATA_W+2 bits.
    function automatic logic [PIX_W-1:0] pix_op(input logic [PIX_W-1:0] px,
                                                input logic [2:0] m,
                                                input logic [DATA_W-1:0] v);
        logic [DATA_W+1:0] sum, lvl;
        logic [DATA_W:0]   add;
        logic [DATA_W-1:0] ch;
        pix_op = '0;
        sum = {2'b0, px[2*DATA_W +: DATA_W]} + {2'b0, px[DATA_W +: DATA_W]} + {2'b0, px[0 +: DATA_W]};
        lvl = {2'b0, v} + {1'b0, v, 1'b0};
        for (int c = 0; c < 3; c++) begin
            ch  = px[c*DATA_W +: DATA_W];
            add = {1'b0, ch} + {1'b0, v};
            pix_op[c*DATA_W +: DATA_W] =
                (m == 3'd1) ? (add[DATA_W] ? '1 : add[DATA_W-1:0]) :
                (m == 3'd2) ? ((ch < v) ? '0 : ch - v) :
                (m == 3'd3) ? ~ch :
                (m == 3'd4) ? ((sum > lvl) ? '1 : '0) : ch;
        end
    endfunction

    assign in_ready  = (state == S_DATA);
    assign HSYNC     = (state == S_DATA);
    assign VSYNC     = (state == S_VSYNC);
    assign busy      = (state != S_IDLE);
    assign xfer      = in_ready && in_valid;
    assign line_end  = (col == 16'(WIDTH - PPC));
    assign frame_end = line_end && (row == 16'(HEIGHT - 1));

    always_comb begin
        proc = '0;
        for (int p = 0; p < PPC; p++)
            proc[p*PIX_W +: PIX_W] = pix_op(in_data[p*PIX_W +: PIX_W], mode_r, value_r);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_VSYNC : S_IDLE;
            S_VSYNC: state_n = (cnt == CNT_W'(STARTUP_DELAY - 1)) ? S_HSYNC : S_VSYNC;
            S_HSYNC: state_n = (cnt == CNT_W'(HSYNC_DELAY - 1)) ? S_DATA : S_HSYNC;
            S_DATA:  state_n = !(xfer && line_end) ? S_DATA : frame_end ? S_IDLE : S_HSYNC;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            mode_r    <= '0;
            value_r   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            ctrl_done <= 1'b0;
        end else begin
            state     <= state_n;
            // The delay counter only runs while staying in a blanking state and clears on any transition.
            cnt       <= (state_n == state && (state == S_VSYNC || state == S_HSYNC)) ? cnt + 1'b1 : '0;
            out_valid <= xfer;
            ctrl_done <= xfer && frame_end;
            if (state == S_IDLE && start) begin
                mode_r  <= mode;
                value_r <= value;
            end
            if (xfer) begin
                out_data <= proc;
                out_row  <= row;
                out_col  <= col;
                col      <= line_end ? '0 : col + 16'(PPC);
                row      <= frame_end ? '0 : line_end ? row + 16'd1 : row;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb_pixel_stream_proc: randomized self-checking bench for pixel_stream_proc against a cycle timeline model
module tb_pixel_stream_proc;
    localparam int W = 8, H = 2, PPC = 2, DW = 8, SD = 4, HD = 3;
    localparam int PX = 3 * DW, BW = PPC * PX, BPL = W / PPC, NBT = H * BPL, MAXV = (1 << DW) - 1;

    logic          HCLK = 0, HRESET = 0, start = 0, in_valid = 0;
    logic [2:0]    mode = 0;
    logic [DW-1:0] value = 0;
    logic [BW-1:0] in_data = 0;
    logic          in_ready, out_valid, VSYNC, HSYNC, busy, ctrl_done;
    logic [BW-1:0] out_data;
    logic [15:0]   out_row, out_col;

    int errors = 0, checks = 0;
    logic [BW-1:0] beats [NBT];
    logic [BW-1:0] got   [NBT];

    pixel_stream_proc #(.WIDTH(W), .HEIGHT(H), .PPC(PPC), .DATA_W(DW),
                        .STARTUP_DELAY(SD), .HSYNC_DELAY(HD)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .ctrl_done(ctrl_done));

    always #5 HCLK = ~HCLK;

    function automatic logic [BW-1:0] rnd_beat();
        return BW'({$urandom(), $urandom()});
    endfunction

    // Reference point operation computed from the channel rules with plain integer arithmetic.
    function automatic logic [BW-1:0] ref_beat(input logic [BW-1:0] d, input int m, input int v);
        logic [BW-1:0] res;
        int r, g, b, ch, o;
        res = '0;
        for (int p = 0; p < PPC; p++) begin
            r = int'(d[p*PX + 2*DW +: DW]);
            g = int'(d[p*PX + DW +: DW]);
            b = int'(d[p*PX +: DW]);
            for (int c = 0; c < 3; c++) begin
                ch = (c == 2) ? r : (c == 1) ? g : b;
                case (m)
                    1: o = (ch + v > MAXV) ? MAXV : ch + v;
                    2: o = (ch - v < 0) ? 0 : ch - v;
                    3: o = MAXV - ch;
                    4: o = (r + g + b > 3 * v) ? MAXV : 0;
                    default: o = ch;
                endcase
                res[p*PX + c*DW +: DW] = DW'(o);
            end
        end
        return res;
    endfunction

    function automatic void fill_random();
        for (int j = 0; j < NBT; j++) beats[j] = rnd_beat();
    endfunction

    // Runs one frame while checking every cycle against a timeline built from the framing rules.
    // kind: 0 vsync, 1 blanking, 2 data transfer, 3 data stall.
    task automatic run_frame(input int fmode, input int fval, input int stall_after, input int stall_len,
                             input int switch_at, input int busy_start_at, input int abort_at);
        int kind[$], bidx[$];
        int b, n, k, prev_x, done_at, stalls;
        logic [5:0] exp_c, got_c;
        logic [BW+31:0] exp_d, got_d;
        b = 0;
        stalls = (stall_after >= 0) ? stall_len : 0;
        for (int i = 0; i < SD; i++) begin kind.push_back(0); bidx.push_back(-1); end
        for (int l = 0; l < H; l++) begin
            for (int i = 0; i < HD; i++) begin kind.push_back(1); bidx.push_back(-1); end
            for (int j = 0; j < BPL; j++) begin
                if (b == stall_after)
                    for (int s = 0; s < stall_len; s++) begin kind.push_back(3); bidx.push_back(-1); end
                kind.push_back(2); bidx.push_back(b); b++;
            end
        end
        n = kind.size();
        @(negedge HCLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_before_start busy=%b required 0", busy); end
        start = 1; mode = 3'(fmode); value = DW'(fval); in_valid = 1; in_data = rnd_beat();
        prev_x = -1; done_at = -1;
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge HCLK);
            start = 0;
            k = (i <= n) ? kind[i-1] : -1;
            exp_c = {k == 0, k >= 2, k >= 2, i <= n, prev_x >= 0, prev_x == NBT - 1};
            got_c = {VSYNC, HSYNC, in_ready, busy, out_valid, ctrl_done};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL ctrl cycle %0d {VSYNC,HSYNC,in_ready,busy,out_valid,ctrl_done}=%b required %b", i, got_c, exp_c);
            end
            if (ctrl_done === 1'b1 && done_at < 0) done_at = i;
            if (prev_x >= 0) begin
                exp_d = {ref_beat(beats[prev_x], fmode, fval), 16'(prev_x / BPL), 16'((prev_x % BPL) * PPC)};
                got_d = {out_data, out_row, out_col};
                got[prev_x] = out_data;
                checks++;
                if (got_d !== exp_d) begin
                    errors++;
                    $display("FAIL beat %0d {data,row,col}=%h required %h", prev_x, got_d, exp_d);
                end
            end
            if (i == abort_at) begin
                HRESET = 0;
                @(negedge HCLK);
                checks++;
                if ({VSYNC, HSYNC, in_ready, busy, out_valid, ctrl_done, out_data, out_row, out_col} !== '0) begin
                    errors++;
                    $display("FAIL abort_reset outputs=%b,%h,%h,%h required all zero",
                             {VSYNC, HSYNC, in_ready, busy, out_valid, ctrl_done}, out_data, out_row, out_col);
                end
                HRESET = 1; in_valid = 0;
                return;
            end
            in_valid = (k == 3) ? 1'b0 : 1'b1;
            in_data = (k == 2) ? beats[bidx[i-1]] : rnd_beat();
            if (i == busy_start_at) start = 1;
            if (i == switch_at) mode = 3'd2;
            prev_x = (k == 2) ? bidx[i-1] : -1;
        end
        checks++;
        if (done_at - 1 != SD + H * (HD + BPL) + stalls) begin
            errors++;
            $display("FAIL frame_length edges=%0d required %0d", done_at - 1, SD + H * (HD + BPL) + stalls);
        end
        @(negedge HCLK);
        in_valid = 0;
        checks++;
        if ({out_valid, ctrl_done, busy, out_data} !== {3'b000, got[NBT-1]}) begin
            errors++;
            $display("FAIL after_frame valid,done,busy=%b data=%h required 000 data=%h",
                     {out_valid, ctrl_done, busy}, out_data, got[NBT-1]);
        end
    endtask

    task automatic test_reset();
        HRESET = 0; start = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if ({VSYNC, HSYNC, in_ready, busy, out_valid, ctrl_done, out_data, out_row, out_col} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d ctrl=%b data=%h row=%0d col=%0d required zero",
                         i, {VSYNC, HSYNC, in_ready, busy, out_valid, ctrl_done}, out_data, out_row, out_col);
            end
        end
        HRESET = 1; start = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_release busy=%b required 0", busy); end
        end
    endtask

    task automatic test_pass();
        fill_random();
        run_frame(0, $urandom_range(0, MAXV), -1, 0, -1, -1, -1);
        for (int j = 0; j < NBT; j++) begin
            checks++;
            if (got[j] !== beats[j]) begin errors++; $display("FAIL pass_identity beat %0d got=%h required %h", j, got[j], beats[j]); end
        end
    endtask

    task automatic test_brightness();
        fill_random();
        beats[0][PX-1:0] = 24'hC8320A;
        run_frame(1, 100, -1, 0, 10, -1, -1);
        checks++;
        if (got[0][PX-1:0] !== 24'hFF966E) begin errors++; $display("FAIL bright_add got=%h required ff966e", got[0][PX-1:0]); end
        fill_random();
        beats[0][PX-1:0] = 24'h32C80A;
        run_frame(2, 100, -1, 0, -1, -1, -1);
        checks++;
        if (got[0][PX-1:0] !== 24'h006400) begin errors++; $display("FAIL bright_sub got=%h required 006400", got[0][PX-1:0]); end
    endtask

    task automatic test_invert_threshold();
        fill_random();
        beats[0] = 48'h3C3C3C_3C3C3C;
        run_frame(3, 90, -1, 0, -1, -1, -1);
        checks++;
        if (got[0] !== 48'hC3C3C3_C3C3C3) begin errors++; $display("FAIL invert got=%h required c3c3c3c3c3c3", got[0]); end
        fill_random();
        beats[0] = 48'h5A5A5A_645A5A;
        run_frame(4, 90, -1, 0, -1, -1, -1);
        checks++;
        if (got[0] !== 48'h000000_FFFFFF) begin errors++; $display("FAIL threshold got=%h required 000000ffffff", got[0]); end
    endtask

    task automatic test_stall();
        fill_random();
        run_frame($urandom_range(0, 7), $urandom_range(0, MAXV), 2, 5, -1, -1, -1);
    endtask

    task automatic test_abort();
        fill_random();
        run_frame(0, 0, -1, 0, -1, 6, SD + (HD + BPL) + HD + 2);
        fill_random();
        run_frame(3, 0, -1, 0, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            fill_random();
            run_frame($urandom_range(0, 7), $urandom_range(0, MAXV), -1, 0, -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_brightness();
        test_invert_threshold();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
